// File: rtl/adc_overrange_detect_pkg.sv
// Shared ADC sample constants and helpers for the overrange/gain blocks.
package adc_overrange_detect_pkg;

  localparam int DEF_ADC_WIDTH = 16;
  localparam int DEF_MAG_WIDTH = DEF_ADC_WIDTH - 1;

  // Operates on a 64-bit sign-extended sample of width w; the most
  // negative code clamps to the largest positive magnitude.
  function automatic logic [63:0] sat_abs(
    input logic [63:0] x,
    input int          w
  );
    logic [63:0] r;
    logic [63:0] lim;
    lim = (64'd1 << (w - 1)) - 64'd1;
    r   = x[63] ? (~x + 64'd1) : x;
    if (r > lim) r = lim;
    return r;
  endfunction

endpackage

// File: rtl/adc_overrange_detect_pulse_stretch.sv
// Retriggerable pulse stretcher: level stays high HOLD_CYCLES after trig.
module ovr_pulse_stretch #(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic level_o
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] LOAD = HW'(HOLD_CYCLES);

  logic [HW-1:0] hold_d, hold_q;
  logic          level_q;

  always_comb begin
    hold_d = hold_q;
    if (trig_i) begin
      hold_d = LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q  <= '0;
      level_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      level_q <= (hold_d != '0);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/adc_overrange_detect.sv
// ADC overrange qualifier with per-window peak magnitude readback.
// Optional ADC_OVR_PIN_EN: hardware overrange pin also counts as a hit.
module adc_overrange_detect
  import adc_overrange_detect_pkg::*;
#(
  parameter int ADC_WIDTH   = DEF_ADC_WIDTH,
  parameter int CONSEC_N    = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int WINDOW_LEN  = 4096
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-2:0] threshold,
  input  logic                 adc_ovr_pin,
  output logic                 overrange,
  output logic [ADC_WIDTH-2:0] peak,
  output logic                 peak_valid
);

  localparam int MAG_W = ADC_WIDTH - 1;
  localparam int CW    = $clog2(CONSEC_N + 1);
  localparam int WW    = $clog2(WINDOW_LEN);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CONSEC_N);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_LEN - 1);

  logic [63:0]      samp_ext;
  logic [MAG_W-1:0] mag_d, mag_q;
  logic             mag_vld_q;
  logic             pin_hit;

  assign samp_ext = {{(64 - ADC_WIDTH){adc_data[ADC_WIDTH-1]}},
                     adc_data};
  assign mag_d    = MAG_W'(sat_abs(samp_ext, ADC_WIDTH));

`ifdef ADC_OVR_PIN_EN
  logic pin_q;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      pin_q <= 1'b0;
    end else begin
      pin_q <= adc_ovr_pin;
    end
  end

  assign pin_hit = pin_q;
`else
  logic unused_pin;

  assign unused_pin = adc_ovr_pin;
  assign pin_hit    = 1'b0;
`endif

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      mag_q     <= '0;
      mag_vld_q <= 1'b0;
    end else begin
      mag_q     <= mag_d;
      mag_vld_q <= adc_valid;
    end
  end

  logic          hit;
  logic          trig;
  logic [CW-1:0] cnt_d, cnt_q;

  assign hit = mag_vld_q && ((mag_q >= threshold) || pin_hit);

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      hit: begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      end
      (mag_vld_q && !hit): begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  assign trig = hit && (cnt_d == CNT_MAX);

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  ovr_pulse_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stretch (
    .clk_i  (aclk),
    .rst_ni (arstn),
    .trig_i (trig),
    .level_o(overrange)
  );

  logic [MAG_W-1:0] acc_d, acc_q;
  logic [MAG_W-1:0] peak_d, peak_q;
  logic [MAG_W-1:0] win_max;
  logic [WW-1:0]    win_d, win_q;
  logic             pv_d, pv_q;

  assign win_max = (mag_q > acc_q) ? mag_q : acc_q;

  // The wrap sample closes its own window; acc restarts from zero.
  always_comb begin
    acc_d  = acc_q;
    win_d  = win_q;
    peak_d = peak_q;
    pv_d   = 1'b0;
    if (mag_vld_q) begin
      if (win_q == WIN_LAST) begin
        peak_d = win_max;
        pv_d   = 1'b1;
        acc_d  = '0;
        win_d  = '0;
      end else begin
        acc_d  = win_max;
        win_d  = win_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      acc_q  <= '0;
      win_q  <= '0;
      peak_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      win_q  <= win_d;
      peak_q <= peak_d;
      pv_q   <= pv_d;
    end
  end

  assign peak       = peak_q;
  assign peak_valid = pv_q;

endmodule
